// File: rtl/div_hilo_ctrl.sv
// EX-stage sequencer for the multi-cycle signed divider; owns architectural HI/LO.
// Stalls EX from DIV issue until div_end; one DRAIN cycle separates successive launches.
module div_hilo_ctrl #(
    parameter int DIV_TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div_req,
    input  logic [31:0] ex_op1,
    input  logic [31:0] ex_op2,
    input  logic        ex_mthi,
    input  logic        ex_mtlo,
    input  logic [31:0] ex_wdata,
    input  logic        ex_flush,
    output logic        div_begin,
    output logic [31:0] div_op1,
    output logic [31:0] div_op2,
    input  logic [31:0] div_result,
    input  logic [31:0] div_remainder,
    input  logic        div_end,
    output logic        stall_req,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_err
);

    localparam int CW = $clog2(DIV_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t         state_q, state_d;
    logic           begin_q, begin_d;
    logic [31:0]    op1_q, op1_d;
    logic [31:0]    op2_q, op2_d;
    logic [31:0]    hi_q, hi_d;
    logic [31:0]    lo_q, lo_d;
    logic           sign_q, sign_d;
    logic           err_q, err_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           timeout;

    // Last RUN cycle allowed: the counter would reach DIV_TIMEOUT on this edge.
    assign timeout = (cnt_q == CW'(DIV_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            begin_q <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sign_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            begin_q <= begin_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sign_q  <= sign_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        begin_d   = begin_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        sign_d    = sign_q;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        stall_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_div_req) begin
                    // Divide by zero and flushed DIVs retire without touching the divider.
                    if (ex_op2 != 32'd0 && !ex_flush) begin
                        op1_d     = ex_op1;
                        op2_d     = ex_op2;
                        sign_d    = ex_op1[31];
                        begin_d   = 1'b1;
                        cnt_d     = '0;
                        stall_req = 1'b1;
                        state_d   = RUN;
                    end
                end else if (!ex_flush) begin
                    if (ex_mthi) hi_d = ex_wdata;
                    if (ex_mtlo) lo_d = ex_wdata;
                end
            end
            RUN: begin
                cnt_d     = cnt_q + CW'(1);
                stall_req = ~div_end;
                if (ex_flush) begin
                    begin_d = 1'b0;
                    state_d = DRAIN;
                end else if (div_end) begin
                    lo_d    = div_result;
                    hi_d    = sign_q ? (32'd0 - div_remainder) : div_remainder;
                    begin_d = 1'b0;
                    state_d = DRAIN;
                end else if (timeout) begin
                    begin_d   = 1'b0;
                    err_d     = 1'b1;
                    stall_req = 1'b0;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                stall_req = ex_div_req;
                if (!ex_flush) begin
                    if (ex_mthi) hi_d = ex_wdata;
                    if (ex_mtlo) lo_d = ex_wdata;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign div_begin = begin_q;
    assign div_op1   = op1_q;
    assign div_op2   = op2_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign div_err   = err_q;
    assign busy      = (state_q != IDLE);

endmodule
